sd_bpdrop_dp: RTL and testbench

//  Srdy/drdy frame-aware backpressure drop with datapath and registered output. Sits between a

---
 rtl/sd_bpdrop_dp_pkg.sv | 22 ++
 rtl/sd_bpdrop_dp_oreg.sv | 51 +++++
 rtl/sd_bpdrop_dp.sv | 171 +++++++++++++++++
 tb/tb_sd_bpdrop_dp.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_bpdrop_dp_pkg.sv
// Shared types for the frame-aware backpressure drop block.
//   state_e  : control FSM state encoding
//   ctl_t    : frame-marker / error sideband carried with each output word
//   CTL_TERM : sideband of the truncation terminator word (data is all zeros)
package sd_bpdrop_dp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_SINK = 2'b11,
        ST_TERM = 2'b10
    } state_e;

    typedef struct packed {
        logic fr_start;
        logic fr_end;
        logic err;
    } ctl_t;

    localparam ctl_t CTL_TERM = '{fr_start: 1'b0, fr_end: 1'b1, err: 1'b1};

endpackage

// File: rtl/sd_bpdrop_dp_oreg.sv
// Output register stage for sd_bpdrop_dp.
//   clk, reset_n          : clock, async active-low reset
//   load                  : capture ld_data/ld_ctl (only asserted when ld_ok_c)
//   ld_data, ld_ctl       : word and sideband to capture
//   p_drdy                : downstream ready
//   ld_ok_c               : register can accept a word this cycle (combinational)
//   p_srdy, p_data,
//   p_fr_start, p_fr_end,
//   p_err                 : registered downstream word
module sd_bpdrop_dp_oreg
    import sd_bpdrop_dp_pkg::*;
#(
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [width-1:0] ld_data,
    input  ctl_t             ld_ctl,
    input  logic             p_drdy,
    output logic             ld_ok_c,
    output logic             p_srdy,
    output logic [width-1:0] p_data,
    output logic             p_fr_start,
    output logic             p_fr_end,
    output logic             p_err
);

    // Empty, or the held word leaves this cycle.
    assign ld_ok_c = !p_srdy || p_drdy;

    // Payload holds while p_srdy & !p_drdy; valid drops when drained without a refill.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_srdy     <= 1'b0;
            p_data     <= '0;
            p_fr_start <= 1'b0;
            p_fr_end   <= 1'b0;
            p_err      <= 1'b0;
        end else if (load) begin
            p_srdy     <= 1'b1;
            p_data     <= ld_data;
            p_fr_start <= ld_ctl.fr_start;
            p_fr_end   <= ld_ctl.fr_end;
            p_err      <= ld_ctl.err;
        end else if (p_drdy) begin
            p_srdy     <= 1'b0;
        end
    end

endmodule

// File: rtl/sd_bpdrop_dp.sv
// Frame-aware srdy/drdy backpressure drop with registered output.
// Drops a whole frame whose start word is stalled too long, truncates a frame
// stalled too long mid-frame and appends an error terminator word.
//   clk, reset_n             : clock, async active-low reset
//   g_max_count, g_mid_max   : start / mid-frame stall limits (mid 0 = no truncation)
//   c_srdy, c_data,
//   c_fr_start, c_fr_end     : upstream word; nc_drdy is the combinational ready
//   p_srdy, p_data, p_fr_*,
//   p_err, p_drdy            : registered downstream word and its ready
//   stat_drop/trunc/orphan   : saturating event counters
// Build option SD_BPDROP_STATS_EN: implement the stat counters (else tied to 0).
module sd_bpdrop_dp
    import sd_bpdrop_dp_pkg::*;
#(
    parameter int unsigned width   = 8,
    parameter int unsigned cnt_sz  = 3,
    parameter int unsigned stat_sz = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [cnt_sz-1:0]  g_max_count,
    input  logic [cnt_sz-1:0]  g_mid_max,
    input  logic               c_srdy,
    input  logic [width-1:0]   c_data,
    input  logic               c_fr_start,
    input  logic               c_fr_end,
    output logic               nc_drdy,
    output logic               p_srdy,
    output logic [width-1:0]   p_data,
    output logic               p_fr_start,
    output logic               p_fr_end,
    output logic               p_err,
    input  logic               p_drdy,
    output logic [stat_sz-1:0] stat_drop,
    output logic [stat_sz-1:0] stat_trunc,
    output logic [stat_sz-1:0] stat_orphan
);

    state_e              state, state_nxt;
    logic [cnt_sz-1:0]   count, count_nxt, count_inc;
    logic                term_pend, term_pend_nxt;
    logic                load, ld_ok;
    logic [width-1:0]    ld_data;
    ctl_t                ld_ctl;
    logic                drop_inc, trunc_inc, orphan_inc;

    // Stall counter saturates rather than wrapping.
    assign count_inc = (count == '1) ? count : count + cnt_sz'(1);

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            term_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            term_pend <= term_pend_nxt;
        end
    end

    // Next-state, ready and load decode. Thresholds compare against the
    // count accumulated before this cycle.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        term_pend_nxt = term_pend;
        nc_drdy       = 1'b0;
        load          = 1'b0;
        ld_data       = c_data;
        ld_ctl        = '{fr_start: c_fr_start, fr_end: c_fr_end, err: 1'b0};
        drop_inc      = 1'b0;
        trunc_inc     = 1'b0;
        orphan_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (c_srdy) begin
                    if (!c_fr_start) begin
                        nc_drdy    = 1'b1;
                        orphan_inc = 1'b1;
                        count_nxt  = '0;
                    end else if (ld_ok) begin
                        nc_drdy   = 1'b1;
                        load      = 1'b1;
                        count_nxt = '0;
                        if (!c_fr_end) state_nxt = ST_XFER;
                    end else if (count >= g_max_count) begin
                        nc_drdy   = 1'b1;
                        drop_inc  = 1'b1;
                        count_nxt = '0;
                        if (!c_fr_end) state_nxt = ST_SINK;
                    end else begin
                        count_nxt = count_inc;
                    end
                end
            end
            ST_XFER: begin
                if (!c_srdy) begin
                    count_nxt = '0;
                end else if (ld_ok) begin
                    nc_drdy   = 1'b1;
                    load      = 1'b1;
                    count_nxt = '0;
                    if (c_fr_end) state_nxt = ST_IDLE;
                end else if ((g_mid_max != '0) && (count >= g_mid_max)) begin
                    nc_drdy       = 1'b1;
                    term_pend_nxt = 1'b1;
                    trunc_inc     = 1'b1;
                    count_nxt     = '0;
                    state_nxt     = c_fr_end ? ST_TERM : ST_SINK;
                end else begin
                    count_nxt = count_inc;
                end
            end
            ST_SINK: begin
                nc_drdy   = 1'b1;
                count_nxt = '0;
                if (c_srdy && c_fr_end) state_nxt = term_pend ? ST_TERM : ST_IDLE;
            end
            ST_TERM: begin
                if (ld_ok) begin
                    load          = 1'b1;
                    ld_data       = '0;
                    ld_ctl        = CTL_TERM;
                    term_pend_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    sd_bpdrop_dp_oreg #(.width(width)) u_oreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .ld_data    (ld_data),
        .ld_ctl     (ld_ctl),
        .p_drdy     (p_drdy),
        .ld_ok_c    (ld_ok),
        .p_srdy     (p_srdy),
        .p_data     (p_data),
        .p_fr_start (p_fr_start),
        .p_fr_end   (p_fr_end),
        .p_err      (p_err)
    );

`ifdef SD_BPDROP_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_drop   <= '0;
            stat_trunc  <= '0;
            stat_orphan <= '0;
        end else begin
            if (drop_inc && (stat_drop != '1))     stat_drop   <= stat_drop + stat_sz'(1);
            if (trunc_inc && (stat_trunc != '1))   stat_trunc  <= stat_trunc + stat_sz'(1);
            if (orphan_inc && (stat_orphan != '1)) stat_orphan <= stat_orphan + stat_sz'(1);
        end
    end
`else
    assign stat_drop   = '0;
    assign stat_trunc  = '0;
    assign stat_orphan = '0;

    logic unused_stat;
    assign unused_stat = ^{drop_inc, trunc_inc, orphan_inc};
`endif

endmodule

// File: tb/tb_sd_bpdrop_dp.sv
// Bench for sd_bpdrop_dp: directed scenarios plus randomized frames, checked
// against a frame-level reference model and an expected-output queue.
module tb_sd_bpdrop_dp;

    localparam int unsigned W    = 8;
    localparam int unsigned CS   = 3;
    localparam int unsigned SS   = 16;
    localparam int          MAXC = (1 << CS) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [CS-1:0] g_max_count, g_mid_max;
    logic          c_srdy, c_fr_start, c_fr_end, nc_drdy;
    logic [W-1:0]  c_data;
    logic          p_srdy, p_fr_start, p_fr_end, p_err, p_drdy;
    logic [W-1:0]  p_data;
    logic [SS-1:0] stat_drop, stat_trunc, stat_orphan;

    sd_bpdrop_dp #(.width(W), .cnt_sz(CS), .stat_sz(SS)) dut (
        .clk(clk), .reset_n(reset_n),
        .g_max_count(g_max_count), .g_mid_max(g_mid_max),
        .c_srdy(c_srdy), .c_data(c_data), .c_fr_start(c_fr_start), .c_fr_end(c_fr_end),
        .nc_drdy(nc_drdy),
        .p_srdy(p_srdy), .p_data(p_data), .p_fr_start(p_fr_start), .p_fr_end(p_fr_end),
        .p_err(p_err), .p_drdy(p_drdy),
        .stat_drop(stat_drop), .stat_trunc(stat_trunc), .stat_orphan(stat_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic         e;
        logic         err;
    } word_t;

    word_t src_q[$];
    word_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int gap_pct, stall_pct;
    int present_cnt, last_wait;
    bit acc_prev;

    // Reference model: frame phase 0 idle, 1 passing, 2 discarding, 3 owes terminator
    int m_phase, m_wait;
    bit m_full, m_owe;
    int m_drop, m_trunc, m_orphan;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int sat_stat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_wait = 0; m_full = 0; m_owe = 0;
        m_drop = 0; m_trunc = 0; m_orphan = 0;
        exp_q.delete();
    endtask

    task automatic push_frame(input int len, input bit orphan);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.d   = W'($urandom);
            w.s   = (i == 0) && !orphan;
            w.e   = (i == len - 1);
            w.err = 1'b0;
            src_q.push_back(w);
        end
    endtask

    // One clock: drive at posedge+1, check and advance the model at posedge+2.
    task automatic step();
        word_t w;
        bit    ld_ok, nc, ld;
        int    ph;
        @(posedge clk); #1;
        if (acc_prev) begin
            void'(src_q.pop_front());
            c_srdy    = 1'b0;
            last_wait = present_cnt;
            present_cnt = 0;
            acc_prev  = 0;
        end
        if (!c_srdy && src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            c_srdy = 1'b1; c_data = src_q[0].d; c_fr_start = src_q[0].s; c_fr_end = src_q[0].e;
        end
        if (c_srdy) present_cnt++;
        p_drdy = ($urandom_range(99) >= stall_pct);
        #1;

`ifdef SD_BPDROP_STATS_EN
        check("stat_drop", stat_drop, sat_stat(m_drop));
        check("stat_trunc", stat_trunc, sat_stat(m_trunc));
        check("stat_orphan", stat_orphan, sat_stat(m_orphan));
`else
        check("stat_drop", stat_drop, 0);
        check("stat_trunc", stat_trunc, 0);
        check("stat_orphan", stat_orphan, 0);
`endif
        check("p_srdy", p_srdy, m_full);
        if (p_srdy && p_drdy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("p_data", p_data, w.d);
                check("p_fr_start", p_fr_start, w.s);
                check("p_fr_end", p_fr_end, w.e);
                check("p_err", p_err, w.err);
            end
        end

        ld_ok = !m_full || p_drdy;
        nc = 0; ld = 0;
        w.d = c_data; w.s = c_fr_start; w.e = c_fr_end; w.err = 1'b0;
        ph = m_phase;
        if (ph == 0) begin
            if (c_srdy) begin
                if (!c_fr_start) begin
                    nc = 1; m_orphan++; m_wait = 0;
                end else if (ld_ok) begin
                    nc = 1; ld = 1; m_wait = 0; m_phase = c_fr_end ? 0 : 1;
                end else if (m_wait >= int'(g_max_count)) begin
                    nc = 1; m_drop++; m_wait = 0; m_phase = c_fr_end ? 0 : 2;
                end else begin
                    m_wait = (m_wait < MAXC) ? m_wait + 1 : MAXC;
                end
            end
        end else if (ph == 1) begin
            if (!c_srdy) begin
                m_wait = 0;
            end else if (ld_ok) begin
                nc = 1; ld = 1; m_wait = 0; if (c_fr_end) m_phase = 0;
            end else if (g_mid_max != 0 && m_wait >= int'(g_mid_max)) begin
                nc = 1; m_owe = 1; m_trunc++; m_wait = 0; m_phase = c_fr_end ? 3 : 2;
            end else begin
                m_wait = (m_wait < MAXC) ? m_wait + 1 : MAXC;
            end
        end else if (ph == 2) begin
            nc = 1; m_wait = 0;
            if (c_srdy && c_fr_end) m_phase = m_owe ? 3 : 0;
        end else begin
            if (ld_ok) begin
                ld = 1; w.d = '0; w.s = 1'b0; w.e = 1'b1; w.err = 1'b1;
                m_owe = 0; m_phase = 0;
            end
        end
        check("nc_drdy", nc_drdy, nc);
        if (ld) begin
            exp_q.push_back(w);
            m_full = 1;
        end else if (p_drdy) begin
            m_full = 0;
        end
        acc_prev = c_srdy && nc_drdy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_src(input int limit);
        int k = 0;
        while ((src_q.size() > 0 || acc_prev) && k < limit) begin step(); k++; end
        if (k >= limit) check("src_timeout", 1, 0);
    endtask

    task automatic drain(input int limit);
        int k = 0;
        gap_pct = 0; stall_pct = 0;
        while ((src_q.size() > 0 || acc_prev || exp_q.size() > 0 || m_full || m_phase != 0) && k < limit) begin
            step(); k++;
        end
        if (k >= limit) check("drain_timeout", 1, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        c_srdy  = 1'b0;
        #1;
        check("rst_p_srdy", p_srdy, 0);
        check("rst_p_data", p_data, 0);
        check("rst_p_err", {p_fr_start, p_fr_end, p_err}, 0);
        check("rst_stats", {stat_drop, stat_trunc, stat_orphan}, 0);
        model_reset();
        src_q.delete();
        acc_prev = 0; present_cnt = 0;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int k;
        c_srdy = 0; c_data = '0; c_fr_start = 0; c_fr_end = 0; p_drdy = 0;
        g_max_count = 3'd3; g_mid_max = 3'd2;
        gap_pct = 0; stall_pct = 0; acc_prev = 0; present_cnt = 0; last_wait = 0;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_nc_drdy", nc_drdy, 0);

        // 4-word frame with ready held high
        push_frame(4, 0);
        drain(100);

        // start word stalled behind a full output register; g_max_count=3
        stall_pct = 100;
        push_frame(1, 0);
        run_src(20);
        push_frame(3, 0);
        run_src(40);
        drain(100);
        push_frame(1, 0); stall_pct = 100; run_src(20);
        push_frame(3, 0);
        k = 0;
        while (src_q.size() == 3 && !acc_prev && k < 20) begin step(); k++; end
        step();
        check("drop_wait_cycles", last_wait, 4);
        drain(100);

        // mid-frame truncation: ready drops after word 2 of 6
        g_mid_max = 3'd2; stall_pct = 0;
        push_frame(6, 0);
        run(2);
        stall_pct = 100; run(14);
        drain(100);

        // truncation disabled, 20-cycle stall
        g_mid_max = 3'd0;
        push_frame(6, 0);
        run(2);
        stall_pct = 100; run(20);
        drain(100);

        // orphan word, then single-word frame timing out with g_max_count=0
        push_frame(1, 1);
        run_src(20);
        g_max_count = 3'd0; stall_pct = 100;
        push_frame(1, 0); run_src(20);
        push_frame(1, 0); run_src(20);
        drain(100);

        // reset while discarding
        g_max_count = 3'd1; stall_pct = 100;
        push_frame(1, 0); run_src(20);
        push_frame(8, 0);
        k = 0;
        while (m_phase != 2 && k < 30) begin step(); k++; end
        run(2);
        do_reset();
        push_frame(3, 0); drain(100);

        // reset while owing the terminator
        g_mid_max = 3'd1; stall_pct = 0;
        push_frame(4, 0);
        run(2);
        stall_pct = 100;
        k = 0;
        while (m_phase != 3 && k < 40) begin step(); k++; end
        run(2);
        do_reset();
        push_frame(3, 0); drain(100);

        // randomized frames with live threshold changes
        for (int chunk = 0; chunk < 12; chunk++) begin
            g_max_count = CS'($urandom_range(0, MAXC));
            g_mid_max   = ($urandom_range(3) == 0) ? '0 : CS'($urandom_range(1, MAXC));
            stall_pct   = $urandom_range(0, 90);
            gap_pct     = $urandom_range(0, 50);
            for (int f = 0; f < 20; f++) begin
                if ($urandom_range(9) == 0) push_frame(1, 1);
                else push_frame($urandom_range(1, 6), 0);
            end
            run_src(4000);
        end
        drain(500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
